// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, the buffer entry layout and the buffer
// control state encoding.
//   ALU_WIDTH   - default ALU data width
//   ALUOP_WIDTH - default ALU opcode width
//   alu_entry_t - one buffered ALU result with its precomputed flags
//   buf_state_t - occupancy state of the result buffer
package alu_pkg;

    localparam int ALU_WIDTH   = 6;
    localparam int ALUOP_WIDTH = 4;

    typedef struct packed {
        logic [ALU_WIDTH-1:0]   result;
        logic                   carry;
        logic                   zero;
        logic                   neg;
        logic [ALUOP_WIDTH-1:0] aluop;
    } alu_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } buf_state_t;

endpackage

// File: rtl/alu_result_buffer_mem.sv
// alu_result_buffer_mem: DEPTH x EW register array for the ALU result buffer.
// Ports:
//   clk     - clock, writes on rising edge
//   wr_en   - write strobe
//   wr_addr - write slot
//   wr_data - entry to store
//   rd_addr - read slot (asynchronous read)
//   rd_data - entry at rd_addr
// Contents carry no reset: a slot is only observed after it was written.
module alu_result_buffer_mem
    import alu_pkg::*;
#(
    parameter int EW    = $bits(alu_entry_t),
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [EW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [EW-1:0] rd_data
);

    logic [EW-1:0] mem_r [DEPTH];

    // Single write port into the entry array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: small FIFO that captures ALU results with their carry,
// zero, negative flags and opcode, and presents the oldest entry to a
// consumer through a valid/ready handshake.
// Ports:
//   clk, reset          - clock; asynchronous active-high reset
//   flush               - synchronous clear of contents and carry_sticky
//   in_valid/in_ready   - producer handshake
//   in_result, in_carryout, in_aluop - ALU result being pushed
//   out_valid/out_ready - consumer handshake
//   out_result, out_carry, out_zero, out_neg, out_aluop - head entry
//   count               - occupancy
//   carry_sticky        - set once any accepted entry carried
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALUOP_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_result,
    input  logic                   in_carryout,
    input  logic [OPW-1:0]         in_aluop,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_result,
    output logic                   out_carry,
    output logic                   out_zero,
    output logic                   out_neg,
    output logic [OPW-1:0]         out_aluop,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   carry_sticky
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Same field order as alu_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             zero;
        logic             neg;
        logic [OPW-1:0]   aluop;
    } buf_entry_t;

    localparam int EW = $bits(buf_entry_t);

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          sticky_r;
    buf_state_t    state_r;
    buf_state_t    state_nxt_s;
    logic          in_ready_s;
    logic          out_valid_s;
    logic          push_s;
    logic          pop_s;
    buf_entry_t    wr_entry_s;
    buf_entry_t    rd_entry_s;
    logic [EW-1:0] rd_bits_s;

    function automatic logic result_is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    function automatic logic result_is_neg(input logic [WIDTH-1:0] v);
        return v[WIDTH-1];
    endfunction

    // Handshake decode; flush suppresses both transfers in its cycle.
    always_comb begin
        in_ready_s  = (state_r != ST_FULL);
        out_valid_s = (state_r != ST_EMPTY);
        push_s      = in_valid && in_ready_s && !flush;
        pop_s       = out_valid_s && out_ready && !flush;
    end

    // Entry assembly; zero/neg are captured here so the head needs no compare.
    always_comb begin
        wr_entry_s.result = in_result;
        wr_entry_s.carry  = in_carryout;
        wr_entry_s.zero   = result_is_zero(in_result);
        wr_entry_s.neg    = result_is_neg(in_result);
        wr_entry_s.aluop  = in_aluop;
    end

    alu_result_buffer_mem #(
        .EW    (EW),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_entry_s),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_bits_s)
    );

    assign rd_entry_s = buf_entry_t'(rd_bits_s);

    // Pointers, occupancy and carry flag; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            sticky_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            sticky_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (push_s && in_carryout) begin
                sticky_r <= 1'b1;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Control state transitions; flush returns to EMPTY from anywhere.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_nxt_s = ST_PARTIAL;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_PARTIAL: begin
                    if (push_s && !pop_s && (count_r == CW'(DEPTH - 1))) begin
                        state_nxt_s = ST_FULL;
                    end else if (pop_s && !push_s && (count_r == CW'(1))) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_PARTIAL;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        state_nxt_s = ST_PARTIAL;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: state_nxt_s = ST_EMPTY;
            endcase
        end
    end

    // Head presentation; fields read as zero whenever no entry is valid.
    always_comb begin
        in_ready  = in_ready_s && !reset;
        out_valid = out_valid_s;
        if (out_valid_s) begin
            out_result = rd_entry_s.result;
            out_carry  = rd_entry_s.carry;
            out_zero   = rd_entry_s.zero;
            out_neg    = rd_entry_s.neg;
            out_aluop  = rd_entry_s.aluop;
        end else begin
            out_result = {WIDTH{1'b0}};
            out_carry  = 1'b0;
            out_zero   = 1'b0;
            out_neg    = 1'b0;
            out_aluop  = {OPW{1'b0}};
        end
    end

    assign count        = count_r;
    assign carry_sticky = sticky_r;

endmodule
